// File: rtl/matrix_result_streamer.sv
// Matrix result streamer: captures a SIZE x SIZE result matrix in one cycle,
// then streams it element by element in row-major order over a valid/ready
// handshake. The flags report overrun (a result offered while busy) and
// count completed frames.
module matrix_result_streamer #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 16,
  localparam int IW        = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] c_in,
  input  logic                                    c_valid,
  output logic                                    c_ready,
  output logic [DATA_WIDTH-1:0]                   m_data,
  output logic [IW-1:0]                           m_row,
  output logic [IW-1:0]                           m_col,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic                                    m_last,
  output logic                                    overrun,
  output logic [7:0]                              frame_cnt
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  state_t                                   state_q;
  logic [IW-1:0]                            row_q, row_d;
  logic [IW-1:0]                            col_q, col_d;
  logic                                     overrun_q;
  logic [7:0]                               frame_cnt_q;
  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] buf_q;

  logic at_last_col;
  logic at_last_row;
  logic capture;

  assign at_last_col = (col_q == LAST_IDX);
  assign at_last_row = (row_q == LAST_IDX);
  assign capture     = (state_q == IDLE) && c_valid;

  // Next row/column position for a transfer: step the column, wrap into the next row.
  always_comb begin
    row_d = row_q;
    col_d = col_q + IW'(1);
    if (at_last_col) begin
      col_d = '0;
      row_d = row_q + IW'(1);
    end
  end

  // Control FSM: capture in IDLE, walk the buffer in STREAM, flag overrun, count frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (c_valid) begin
            state_q <= STREAM;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        STREAM: begin
          // c_ready is low for the whole frame, including the final transfer.
          if (c_valid) begin
            overrun_q <= 1'b1;
          end
          if (m_ready) begin
            if (at_last_col && at_last_row) begin
              state_q     <= IDLE;
              row_q       <= '0;
              col_q       <= '0;
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Snapshot of the matrix; only written on capture so c_in may change freely while streaming.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_q <= c_in;
    end
  end

  assign c_ready   = (state_q == IDLE);
  assign m_valid   = (state_q == STREAM);
  assign m_row     = row_q;
  assign m_col     = col_q;
  assign m_last    = m_valid && at_last_row && at_last_col;
  // Gate data to zero outside STREAM so the output is clean in reset and idle.
  assign m_data    = m_valid ? buf_q[row_q][col_q] : '0;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule
